// File: rtl/div_32_seq_if.sv
// Start/busy/done handshake and operand/result bundle for div_32_seq.
// Master drives the request side; slave (the divider) drives status and results.
interface div_32_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sign_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, sign_op, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, sign_op, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_32_seq.sv
// Iterative restoring divider, one trial subtraction per cycle (optional SIGNED_DIV_EN).
// Latency: done WIDTH+1 cycles after accepted start; divide-by-zero done after 1 cycle.
// Backpressure: start accepted only in IDLE/DONE, ignored while busy; results held until next start.
module div_32_seq #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    div_32_seq_if.slave d
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dvs;
    logic [CNT_W-1:0] cnt;
    logic             neg_q;
    logic             neg_r;

    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             dbz_r;

    logic             accept;
    logic             last_step;
    logic             divisor_zero;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH+1:0] trial;
    logic [WIDTH:0]   rem_step;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic             cap_neg_q;
    logic             cap_neg_r;

`ifdef SIGNED_DIV_EN
    logic dvd_neg;
    logic dvs_neg;

    always_comb begin
        dvd_neg   = d.sign_op && d.dividend[WIDTH-1];
        dvs_neg   = d.sign_op && d.divisor[WIDTH-1];
        // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude
        dvd_mag   = dvd_neg ? (~d.dividend + WIDTH'(1)) : d.dividend;
        dvs_mag   = dvs_neg ? (~d.divisor + WIDTH'(1)) : d.divisor;
        cap_neg_q = dvd_neg ^ dvs_neg;
        cap_neg_r = dvd_neg;
    end
`else
    logic sign_op_unused;

    assign sign_op_unused = d.sign_op;
    assign dvd_mag        = d.dividend;
    assign dvs_mag        = d.divisor;
    assign cap_neg_q      = 1'b0;
    assign cap_neg_r      = 1'b0;
`endif

    assign divisor_zero = (d.divisor == '0);
    assign accept       = d.start && ((state == S_IDLE) || (state == S_DONE));
    assign last_step    = (state == S_CALC) && (cnt == CNT_W'(WIDTH - 1));

    // Restoring keeps rem below the divisor, so its top bit only matters inside the trial.
    logic rem_msb_unused;
    assign rem_msb_unused = rem[WIDTH];

    always_comb begin
        rem_shift = {rem[WIDTH-1:0], q[WIDTH-1]};
        trial     = {1'b0, rem_shift} - {2'b00, dvs};
        if (!trial[WIDTH+1]) begin
            rem_step = trial[WIDTH:0];
            q_step   = {q[WIDTH-2:0], 1'b1};
        end else begin
            rem_step = rem_shift;
            q_step   = {q[WIDTH-2:0], 1'b0};
        end
        q_fix = neg_q ? (~q_step + WIDTH'(1)) : q_step;
        r_fix = neg_r ? (~rem_step[WIDTH-1:0] + WIDTH'(1)) : rem_step[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (d.start) begin
                    state_nxt = divisor_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (last_step) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (d.start) begin
                    state_nxt = divisor_zero ? S_DONE : S_CALC;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem         <= '0;
            q           <= '0;
            dvs         <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            dbz_r       <= 1'b0;
        end else if (accept) begin
            rem   <= '0;
            q     <= dvd_mag;
            dvs   <= dvs_mag;
            cnt   <= '0;
            neg_q <= cap_neg_q;
            neg_r <= cap_neg_r;
            if (divisor_zero) begin
                quotient_r  <= '1;
                remainder_r <= d.dividend;
                dbz_r       <= 1'b1;
            end
        end else if (state == S_CALC) begin
            rem <= rem_step;
            q   <= q_step;
            cnt <= cnt + 1'b1;
            // Sign fixup rides on the final step so results land with the DONE entry
            if (last_step) begin
                quotient_r  <= q_fix;
                remainder_r <= r_fix;
                dbz_r       <= 1'b0;
            end
        end
    end

    assign d.busy        = (state == S_CALC);
    assign d.done        = (state == S_DONE);
    assign d.quotient    = quotient_r;
    assign d.remainder   = remainder_r;
    assign d.div_by_zero = dbz_r;

endmodule

// File: tb/tb_div_32_seq.sv
// Directed-vector bench for div_32_seq: table of operations plus hand-written
// back-to-back, mid-op reset and ignored-start sequences.
module tb_div_32_seq;
    logic clk;
    logic rst;

    div_32_seq_if #(.WIDTH(32)) dif ();

    div_32_seq #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .d   (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dvd;
        logic [31:0] dvs;
        logic        sgn;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t vecs[11];
    int   errors;
    int   checks;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] dvd, input logic [31:0] dvs, input logic sgn,
                          output logic [31:0] q, output logic [31:0] r, output logic dbz,
                          output int lat, output logic busy1);
        @(posedge clk);
        #1;
        dif.start    = 1'b1;
        dif.dividend = dvd;
        dif.divisor  = dvs;
        dif.sign_op  = sgn;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        lat       = 1;
        busy1     = dif.busy;
        while (!dif.done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        q   = dif.quotient;
        r   = dif.remainder;
        dbz = dif.div_by_zero;
    endtask

    initial begin
        logic [31:0] q, r, mid_q;
        logic        dbz, busy1;
        int          lat, n, dones;

        errors = 0;
        checks = 0;

        vecs[0] = '{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33};
        vecs[1] = '{32'hDEADBEEF, 32'd0, 1'b0, 32'hFFFFFFFF, 32'hDEADBEEF, 1'b1, 1};
        vecs[2] = '{32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0, 33};
        vecs[3] = '{32'd0, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0, 33};
        vecs[4] = '{32'h12345678, 32'd1, 1'b0, 32'h12345678, 32'd0, 1'b0, 33};
        vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd1, 32'd0, 1'b0, 33};
        vecs[6] = '{32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 1'b0, 33};
`ifdef SIGNED_DIV_EN
        vecs[7] = '{32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33};
        vecs[8] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0, 33};
        vecs[9] = '{32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 1'b0, 33};
`else
        vecs[7] = '{32'hFFFFFFF9, 32'd2, 1'b1, 32'h7FFFFFFC, 32'd1, 1'b0, 33};
        vecs[8] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0, 32'h80000000, 1'b0, 33};
        vecs[9] = '{32'd7, 32'hFFFFFFFE, 1'b1, 32'd0, 32'd7, 1'b0, 33};
`endif
        vecs[10] = '{32'd0, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b1, 1};

        rst          = 1'b1;
        dif.start    = 1'b0;
        dif.sign_op  = 1'b0;
        dif.dividend = '0;
        dif.divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, dif.busy}, 32'd0);
        chk("reset_done", {31'd0, dif.done}, 32'd0);
        chk("reset_q", dif.quotient, 32'd0);
        chk("reset_r", dif.remainder, 32'd0);
        chk("reset_dbz", {31'd0, dif.div_by_zero}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].dvd, vecs[i].dvs, vecs[i].sgn, q, r, dbz, lat, busy1);
            chk($sformatf("v%0d_q", i), q, vecs[i].q);
            chk($sformatf("v%0d_r", i), r, vecs[i].r);
            chk($sformatf("v%0d_dbz", i), {31'd0, dbz}, {31'd0, vecs[i].dbz});
            chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_busy1", i), {31'd0, busy1}, {31'd0, (vecs[i].lat > 1)});
        end

        // Back-to-back: start held during the DONE cycle of 100/7
        run_op(32'd100, 32'd7, 1'b0, q, r, dbz, lat, busy1);
        chk("b2b_first_q", q, 32'd14);
        dif.start    = 1'b1;
        dif.dividend = 32'hFFFFFFFF;
        dif.divisor  = 32'h10;
        dif.sign_op  = 1'b0;
        n     = 0;
        mid_q = '0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) dif.start = 1'b0;
            if (n == 5) mid_q = dif.quotient;
        end while (!dif.done && n < 100);
        chk("b2b_gap", n, 33);
        chk("b2b_frozen_q", mid_q, 32'd14);
        chk("b2b_q", dif.quotient, 32'h0FFFFFFF);
        chk("b2b_r", dif.remainder, 32'hF);

        // Reset during cycle 10 of 1000/3
        @(posedge clk);
        #1;
        dif.start    = 1'b1;
        dif.dividend = 32'd1000;
        dif.divisor  = 32'd3;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        chk("rst_pre_busy", {31'd0, dif.busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", {31'd0, dif.busy}, 32'd0);
        chk("rst_done", {31'd0, dif.done}, 32'd0);
        chk("rst_q", dif.quotient, 32'd0);
        chk("rst_r", dif.remainder, 32'd0);
        chk("rst_dbz", {31'd0, dif.div_by_zero}, 32'd0);
        dones = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (dif.done) dones++;
        end
        chk("rst_no_done", dones, 0);

        // Start pulsed mid-CALC must be ignored
        @(posedge clk);
        #1;
        dif.start    = 1'b1;
        dif.dividend = 32'd9;
        dif.divisor  = 32'd4;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        dones     = 0;
        for (int i = 1; i <= 80; i++) begin
            if (i == 5) begin
                dif.start    = 1'b1;
                dif.dividend = 32'd5;
                dif.divisor  = 32'd2;
            end
            if (i == 6) dif.start = 1'b0;
            @(posedge clk);
            #1;
            if (dif.done) dones++;
        end
        chk("ign_dones", dones, 1);
        chk("ign_q", dif.quotient, 32'd2);
        chk("ign_r", dif.remainder, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
